// File: rtl/mapper_mem_req_pkg.sv
// Shared definitions for the slot-mapper memory request stage.
package mapper_mem_req_pkg;

  localparam int MAP_ADDR_W = 27;
  localparam int MAP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mapper_mem_req_watchdog.sv
// Request watchdog: counts cycles while enabled, flags the terminal cycle.
// TIMEOUT of 0 removes the counter and tc never asserts.
module mapper_mem_req_watchdog
  import mapper_mem_req_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [CW-1:0] count;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en) begin
          count <= count + 1'b1;
        end
      end

      // tc lands on the TIMEOUT-th cycle of the enabled window
      assign tc = en && (count == CW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign tc = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mapper_mem_req.sv
// Turns each mapper access into one registered req/ack memory request and
// stalls the CPU until it completes. Optional read cache: MAPPER_MEM_REQ_RDCACHE_EN.
//
// state | meaning
// IDLE  | waiting for a fresh ram_cs rising edge
// REQ   | mem_req held, waiting for mem_ack or watchdog
// DONE  | access finished, waiting for ram_cs to drop
module mapper_mem_req
  import mapper_mem_req_pkg::*;
#(
  parameter int ADDR_W  = MAP_ADDR_W,
  parameter int DATA_W  = MAP_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rnw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  state_t      state;
  logic        cs_q;
  logic        start;
  logic        wd_tc;
  logic        cache_hit;
  logic [DATA_W-1:0] cache_rd;

  assign start    = ram_cs && !cs_q && (state == IDLE);
  assign cpu_wait = start || (state == REQ);

  mapper_mem_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (state == REQ),
    .tc    (wd_tc)
  );

`ifdef MAPPER_MEM_REQ_RDCACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '1;
      cache_data  <= '1;
    end else if (start && !rnw) begin
      cache_valid <= 1'b0;
    end else if (state == REQ && mem_ack && !mem_we) begin
      cache_valid <= 1'b1;
      cache_tag   <= mem_addr;
      cache_data  <= mem_rdata;
    end else if (state == REQ && wd_tc) begin
      cache_valid <= 1'b0;
    end
  end

  assign cache_hit = rnw && cache_valid && (addr == cache_tag);
  assign cache_rd  = cache_data;
`else
  assign cache_hit = 1'b0;
  assign cache_rd  = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cs_q        <= 1'b0;
      rd_data     <= '1;
      rd_valid    <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '1;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      cs_q     <= ram_cs;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cache_hit) begin
              rd_data  <= cache_rd;
              rd_valid <= 1'b1;
              state    <= DONE;
            end else begin
              mem_addr  <= addr;
              mem_we    <= ~rnw;
              mem_wdata <= cpu_wdata;
              mem_req   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // an ack on the terminal watchdog cycle still counts as success
          if (mem_ack || wd_tc) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rd_data  <= mem_ack ? mem_rdata : '1;
              rd_valid <= 1'b1;
            end
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
            state <= ram_cs ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!ram_cs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_mem_req.sv
// Directed bench for mapper_mem_req with a read-data scoreboard.
module tb_mapper_mem_req;

  localparam int AW = 27;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_cs;
  logic [AW-1:0] addr;
  logic          rnw;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wait;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          timeout_err;

  int checks = 0;
  int failures = 0;
  int req_rises = 0;
  int base;
  logic req_prev = 1'b0;
  logic [DW-1:0] exp_q[$];

  mapper_mem_req #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ram_cs      (ram_cs),
    .addr        (addr),
    .rnw         (rnw),
    .cpu_wdata   (cpu_wdata),
    .cpu_wait    (cpu_wait),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every rd_valid pulse consumes one expected read value
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end else begin
        chk("rd_data_sb", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // starts an access at the current tick, acks it in its ack_cyc-th REQ cycle
  task automatic run_access(input logic [AW-1:0] a, input logic r, input logic [DW-1:0] wd,
                            input int ack_cyc, input logic [DW-1:0] rdata);
    ram_cs = 1'b1; addr = a; rnw = r; cpu_wdata = wd;
    #1;
    chk("start_wait", 32'(cpu_wait), 32'd1);
    if (r) exp_q.push_back(rdata);
    for (int i = 1; i <= ack_cyc; i++) begin
      tick();
      chk("req_level", 32'(mem_req), 32'd1);
      chk("req_addr", 32'(mem_addr), 32'(a));
      chk("req_we", 32'(mem_we), 32'(!r));
      if (!r) chk("req_wdata", 32'(mem_wdata), 32'(wd));
      chk("req_wait", 32'(cpu_wait), 32'd1);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("ack_req_drop", 32'(mem_req), 32'd0);
    chk("ack_wait_drop", 32'(cpu_wait), 32'd0);
    chk("ack_rd_valid", 32'(rd_valid), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; ram_cs = 1'b0; addr = '1; rnw = 1'b1; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_wait", 32'(cpu_wait), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'hFF);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h7FF_FFFF);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // read with ack in the third REQ cycle, then cs held for 20 cycles
    base = req_rises;
    run_access(27'h0004000, 1'b1, 8'h00, 3, 8'h5A);
    chk("read_rd_data", 32'(rd_data), 32'h5A);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_wait", 32'(cpu_wait), 32'd0);
      chk("held_req", 32'(mem_req), 32'd0);
    end
    chk("held_one_req", 32'(req_rises - base), 32'd1);
    ram_cs = 1'b0;
    tick();
    run_access(27'h0004001, 1'b1, 8'h00, 1, 8'h3C);
    chk("retrigger_req", 32'(req_rises - base), 32'd2);
    ram_cs = 1'b0;
    tick();

    // write: data held through ack, read data untouched
    run_access(27'h0000123, 1'b0, 8'hC3, 2, 8'hEE);
    chk("write_rd_data", 32'(rd_data), 32'h3C);
    ram_cs = 1'b0;
    tick();

    // timeout with no ack
    ram_cs = 1'b1; addr = 27'h0000200; rnw = 1'b1;
    exp_q.push_back(8'hFF);
    for (int i = 1; i <= TO; i++) begin
      tick();
      chk("to_req_level", 32'(mem_req), 32'd1);
      chk("to_no_err", 32'(timeout_err), 32'd0);
    end
    tick();
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_rd_data", 32'(rd_data), 32'hFF);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_wait", 32'(cpu_wait), 32'd0);
    ram_cs = 1'b0;
    tick(); tick(); tick();
    chk("to_err_sticky", 32'(timeout_err), 32'd1);

    reset = 1'b1;
    #1;
    chk("rst_clears_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // ack on the terminal watchdog cycle wins
    run_access(27'h0000210, 1'b1, 8'h00, TO, 8'h66);
    chk("tc_ack_no_err", 32'(timeout_err), 32'd0);
    chk("tc_ack_rd_data", 32'(rd_data), 32'h66);
    ram_cs = 1'b0;
    tick();

    // cs dropped during REQ: request finishes, FSM returns to IDLE
    ram_cs = 1'b1; addr = 27'h0000300; rnw = 1'b1;
    tick();
    chk("abandon_req", 32'(mem_req), 32'd1);
    ram_cs = 1'b0;
    tick();
    chk("abandon_req_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    mem_ack = 1'b0;
    chk("abandon_req_drop", 32'(mem_req), 32'd0);
    chk("abandon_rd_data", 32'(rd_data), 32'hA5);
    run_access(27'h0000301, 1'b1, 8'h00, 1, 8'h11);
    ram_cs = 1'b0;
    tick();

    // reset in the middle of REQ, then a stray ack
    ram_cs = 1'b1; addr = 27'h0000400; rnw = 1'b1;
    tick();
    chk("mid_req", 32'(mem_req), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    ram_cs = 1'b0;
    tick(); tick();
    reset = 1'b0;
    base = req_rises;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_rd_data", 32'(rd_data), 32'hFF);
    chk("stray_wait", 32'(cpu_wait), 32'd0);
    chk("stray_no_req", 32'(req_rises - base), 32'd0);

    // read cache
    run_access(27'h0000100, 1'b1, 8'h00, 2, 8'h77);
    ram_cs = 1'b0;
    tick();
    base = req_rises;
`ifdef MAPPER_MEM_REQ_RDCACHE_EN
    ram_cs = 1'b1; addr = 27'h0000100; rnw = 1'b1;
    exp_q.push_back(8'h77);
    #1;
    chk("hit_start_wait", 32'(cpu_wait), 32'd1);
    tick();
    chk("hit_no_req", 32'(mem_req), 32'd0);
    chk("hit_wait", 32'(cpu_wait), 32'd0);
    chk("hit_rd_valid", 32'(rd_valid), 32'd1);
    chk("hit_rd_data", 32'(rd_data), 32'h77);
    chk("hit_req_count", 32'(req_rises - base), 32'd0);
`else
    run_access(27'h0000100, 1'b1, 8'h00, 2, 8'h78);
    chk("nocache_req_count", 32'(req_rises - base), 32'd1);
`endif
    ram_cs = 1'b0;
    tick();
    run_access(27'h0000555, 1'b0, 8'h12, 1, 8'h00);
    ram_cs = 1'b0;
    tick();
    run_access(27'h0000100, 1'b1, 8'h00, 1, 8'h79);
    chk("post_write_rd_data", 32'(rd_data), 32'h79);
    ram_cs = 1'b0;
    tick(); tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
